// File: rtl/instr_encoder_if.sv
// Request/instruction handshake bundle for instr_encoder.
// master drives requests and accepts words; slave is the encoder.
interface instr_encoder_if #(
  parameter int unsigned CNT_W = 16
);
  logic             req_valid;
  logic             req_ready;
  logic [4:0]       req_op;
  logic [11:0]      req_k;
  logic             instr_valid;
  logic             instr_ready;
  logic [14:0]      instr;
  logic             instr_last;
  logic             err;
  logic [CNT_W-1:0] word_cnt;

  modport master (
    output req_valid, req_op, req_k, instr_ready,
    input  req_ready, instr_valid, instr, instr_last, err, word_cnt
  );

  modport slave (
    input  req_valid, req_op, req_k, instr_ready,
    output req_ready, instr_valid, instr, instr_last, err, word_cnt
  );
endinterface

// File: rtl/instr_encoder.sv
// Encodes mnemonic requests into 15-bit instruction words; extracodes are
// emitted as a 00006 prefix word followed by the main word.
module instr_encoder #(
  parameter int unsigned CNT_W = 16
) (
  input  logic          clock,
  input  logic          rst_l,
  input  logic          flush,
  instr_encoder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, PREFIX, MAIN} state_t;

  localparam logic [14:0]      PREFIX_WORD = 15'o00006;
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_t           state_q, state_d;
  logic [14:0]      word_q, word_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q;

  logic [14:0] enc_word;
  logic        enc_extra;
  logic        enc_illegal;
  logic [4:0]  io_sub;
  logic        k_hi10;   // K > o1777
  logic        k_hi9;    // K > o777
  logic        handshake;

  assign k_hi10 = |bus.req_k[11:10];
  assign k_hi9  = |bus.req_k[11:9];

  always_comb begin
    enc_word    = '0;
    enc_extra   = 1'b0;
    enc_illegal = 1'b0;
    io_sub      = bus.req_op - 5'd13;
    case (bus.req_op)
      5'd0: begin
        enc_word    = {3'o0, bus.req_k};
        enc_illegal = (bus.req_k == 12'd2) || (bus.req_k == 12'd4) ||
                      (bus.req_k == 12'd6);
      end
      5'd1:  enc_word = 15'o00002;
      5'd2: begin
        enc_word    = {3'o1, bus.req_k};
        enc_illegal = !k_hi10;
      end
      5'd3:  enc_word = {3'o3, bus.req_k};
      5'd4:  enc_word = {3'o4, bus.req_k};
      5'd5:  enc_word = {3'o6, bus.req_k};
      5'd6:  enc_word = {3'o7, bus.req_k};
      5'd7:  begin enc_word = {3'o2, 2'b01, bus.req_k[9:0]}; enc_illegal = k_hi10; end
      5'd8:  begin enc_word = {3'o2, 2'b10, bus.req_k[9:0]}; enc_illegal = k_hi10; end
      5'd9:  begin enc_word = {3'o2, 2'b11, bus.req_k[9:0]}; enc_illegal = k_hi10; end
      5'd10: begin enc_word = {3'o5, 2'b00, bus.req_k[9:0]}; enc_illegal = k_hi10; end
      5'd11: begin enc_word = {3'o5, 2'b10, bus.req_k[9:0]}; enc_illegal = k_hi10; end
      5'd12: begin enc_word = {3'o5, 2'b11, bus.req_k[9:0]}; enc_illegal = k_hi10; end
      5'd13, 5'd14, 5'd15, 5'd16, 5'd17, 5'd18, 5'd19: begin
        enc_word    = {3'o0, io_sub[2:0], bus.req_k[8:0]};
        enc_extra   = 1'b1;
        enc_illegal = k_hi9;
      end
      5'd20: begin
        enc_word    = {3'o1, bus.req_k};
        enc_extra   = 1'b1;
        enc_illegal = !k_hi10;
      end
      5'd21: begin
        enc_word    = {3'o1, bus.req_k};
        enc_extra   = 1'b1;
        enc_illegal = k_hi10;
      end
      5'd22: begin enc_word = {3'o2, 2'b01, bus.req_k[9:0]}; enc_extra = 1'b1; enc_illegal = k_hi10; end
      5'd23: begin enc_word = {3'o2, 2'b10, bus.req_k[9:0]}; enc_extra = 1'b1; enc_illegal = k_hi10; end
      5'd24: begin enc_word = {3'o2, 2'b11, bus.req_k[9:0]}; enc_extra = 1'b1; enc_illegal = k_hi10; end
      5'd25: begin enc_word = {3'o5, bus.req_k}; enc_extra = 1'b1; end
      5'd26: begin
        enc_word    = {3'o6, bus.req_k};
        enc_extra   = 1'b1;
        enc_illegal = !k_hi10;
      end
      5'd27: begin
        enc_word    = {3'o6, bus.req_k};
        enc_extra   = 1'b1;
        enc_illegal = k_hi10;
      end
      5'd28: begin enc_word = {3'o7, bus.req_k}; enc_extra = 1'b1; end
      default: enc_illegal = 1'b1;
    endcase
  end

  assign handshake = (state_q != IDLE) && bus.instr_ready;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (enc_illegal) begin
            err_d = 1'b1;
          end else begin
            word_d  = enc_word;
            state_d = enc_extra ? PREFIX : MAIN;
          end
        end
      end
      PREFIX:  if (bus.instr_ready) state_d = MAIN;
      MAIN:    if (bus.instr_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Flush overrides both acceptance and any handshake in this cycle.
    if (flush) begin
      state_d = IDLE;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_l) begin
      state_q <= IDLE;
      word_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      err_q   <= err_d;
      if (handshake && !flush) cnt_q <= cnt_q + CNT_ONE;
    end
  end

  // All outputs decode from registered state only.
  assign bus.req_ready   = (state_q == IDLE);
  assign bus.instr_valid = (state_q != IDLE);
  assign bus.instr_last  = (state_q == MAIN);
  assign bus.instr       = (state_q == MAIN)   ? word_q      :
                           (state_q == PREFIX) ? PREFIX_WORD : '0;
  assign bus.err         = err_q;
  assign bus.word_cnt    = cnt_q;

endmodule
